// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, operator codes and entry states for the calculator
package calc_pkg;

    typedef enum logic [4:0] {
        KEY_0   = 5'd0,
        KEY_1   = 5'd1,
        KEY_2   = 5'd2,
        KEY_3   = 5'd3,
        KEY_4   = 5'd4,
        KEY_5   = 5'd5,
        KEY_6   = 5'd6,
        KEY_7   = 5'd7,
        KEY_8   = 5'd8,
        KEY_9   = 5'd9,
        KEY_MUL = 5'd10,
        KEY_DIV = 5'd11,
        KEY_ADD = 5'd12,
        KEY_SUB = 5'd13,
        KEY_MOD = 5'd14,
        KEY_EQ  = 5'd15,
        KEY_CLR = 5'd16,
        KEY_BSP = 5'd17,
        KEY_NEG = 5'd18
    } key_e;

    // Operator codes shared with the arithmetic stage
    typedef enum logic [2:0] {
        OP_NULL = 3'd0,
        OP_MUL  = 3'd1,
        OP_DIV  = 3'd2,
        OP_ADD  = 3'd3,
        OP_SUB  = 3'd4,
        OP_MOD  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        S_OP1  = 2'd0,
        S_OP2  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Operator keys are laid out in the same order as the op codes, offset by 9
    function automatic logic [2:0] key_to_op(input logic [4:0] code);
        logic [4:0] t;
        t = code - 5'd9;
        return t[2:0];
    endfunction

endpackage

// File: rtl/calc_operand_acc.sv
// rtl/calc_operand_acc.sv - sign/magnitude decimal operand accumulator
module calc_operand_acc
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 6,
    parameter int MAG_W      = 20,
    parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
    input  logic        sw_clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        load,
    input  logic        app,
    input  logic        bsp,
    input  logic        neg,
    input  logic [3:0]  digit,
    output logic [31:0] value
);

    logic             sign;
    logic [MAG_W-1:0] mag;
    logic [CNT_W-1:0] cnt;
    logic [MAG_W-1:0] mag_app;
    logic [CNT_W-1:0] limit;
    logic [31:0]      mag_ext;

    // Next magnitude for a digit append; the minus sign costs one display position
    always_comb begin
        mag_app = (mag << 3) + (mag << 1) + MAG_W'(digit);
        limit   = sign ? CNT_W'(MAX_DIGITS - 1) : CNT_W'(MAX_DIGITS);
        mag_ext = 32'(mag);
        value   = sign ? (32'd0 - mag_ext) : mag_ext;
    end

    // Operand edit register; clear dominates, then load, then the edit strobes
    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            sign <= 1'b0;
            mag  <= '0;
            cnt  <= '0;
        end else if (clr) begin
            sign <= 1'b0;
            mag  <= '0;
            cnt  <= '0;
        end else if (load) begin
            sign <= 1'b0;
            mag  <= MAG_W'(digit);
            cnt  <= (digit != 4'd0) ? CNT_W'(1) : '0;
        end else if (app) begin
            if (!(mag == '0 && digit == 4'd0) && cnt < limit) begin
                mag <= mag_app;
                cnt <= cnt + CNT_W'(1);
            end
        end else if (bsp) begin
            if (cnt != '0) begin
                mag <= mag / MAG_W'(10);
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    sign <= 1'b0;
                end
            end else begin
                sign <= 1'b0;
            end
        end else if (neg) begin
            if (mag != '0 && !(!sign && cnt == CNT_W'(MAX_DIGITS))) begin
                sign <= ~sign;
            end
        end
    end

endmodule

// File: rtl/calc_key_entry.sv
// rtl/calc_key_entry.sv - key-event driven operand/operator entry for the calculator
module calc_key_entry
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS = 6,
    parameter int MAG_W      = 20
) (
    input  logic        sw_clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [4:0]  key_code,
    output logic [31:0] operand1,
    output logic [31:0] operand2,
    output logic [2:0]  operator,
    output logic [31:0] disp_val,
    output logic        disp_sel,
    output logic [1:0]  state
);

    state_e     cur_state, nxt_state;
    logic [2:0] pend_op, pend_nxt, oper_nxt;
    logic       sel_nxt;
    logic       is_digit, is_op, is_eq, is_clr, is_bsp, is_neg;
    logic       a1_clr, a1_load, a1_app, a1_bsp, a1_neg;
    logic       a2_clr, a2_app, a2_bsp, a2_neg;
    logic       op2_empty;

    assign is_digit  = key_valid && (key_code <= 5'd9);
    assign is_op     = key_valid && (key_code >= 5'd10) && (key_code <= 5'd14);
    assign is_eq     = key_valid && (key_code == KEY_EQ);
    assign is_clr    = key_valid && (key_code == KEY_CLR);
    assign is_bsp    = key_valid && (key_code == KEY_BSP);
    assign is_neg    = key_valid && (key_code == KEY_NEG);
    // A zero value means no digits have been entered yet
    assign op2_empty = (operand2 == 32'd0);
    assign state     = cur_state;

    calc_operand_acc #(.MAX_DIGITS(MAX_DIGITS), .MAG_W(MAG_W)) u_acc1 (
        .sw_clk (sw_clk),
        .rst    (rst),
        .clr    (a1_clr),
        .load   (a1_load),
        .app    (a1_app),
        .bsp    (a1_bsp),
        .neg    (a1_neg),
        .digit  (key_code[3:0]),
        .value  (operand1)
    );

    calc_operand_acc #(.MAX_DIGITS(MAX_DIGITS), .MAG_W(MAG_W)) u_acc2 (
        .sw_clk (sw_clk),
        .rst    (rst),
        .clr    (a2_clr),
        .load   (1'b0),
        .app    (a2_app),
        .bsp    (a2_bsp),
        .neg    (a2_neg),
        .digit  (key_code[3:0]),
        .value  (operand2)
    );

    // Entry state register
    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            cur_state <= S_OP1;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Pending/committed operator and display select
    always_ff @(posedge sw_clk or negedge rst) begin
        if (!rst) begin
            pend_op  <= OP_NULL;
            operator <= OP_NULL;
            disp_sel <= 1'b0;
        end else begin
            pend_op  <= pend_nxt;
            operator <= oper_nxt;
            disp_sel <= sel_nxt;
        end
    end

    // Key dispatch: next state, operator bookkeeping and operand edit strobes
    always_comb begin
        nxt_state = cur_state;
        pend_nxt  = pend_op;
        oper_nxt  = operator;
        sel_nxt   = disp_sel;
        a1_clr    = 1'b0;
        a1_load   = 1'b0;
        a1_app    = 1'b0;
        a1_bsp    = 1'b0;
        a1_neg    = 1'b0;
        a2_clr    = 1'b0;
        a2_app    = 1'b0;
        a2_bsp    = 1'b0;
        a2_neg    = 1'b0;
        if (is_clr) begin
            nxt_state = S_OP1;
            pend_nxt  = OP_NULL;
            oper_nxt  = OP_NULL;
            sel_nxt   = 1'b0;
            a1_clr    = 1'b1;
            a2_clr    = 1'b1;
        end else begin
            case (cur_state)
                S_OP1: begin
                    a1_app = is_digit;
                    a1_bsp = is_bsp;
                    a1_neg = is_neg;
                    if (is_op) begin
                        pend_nxt  = key_to_op(key_code);
                        a2_clr    = 1'b1;
                        nxt_state = S_OP2;
                    end
                end
                S_OP2: begin
                    a2_app = is_digit;
                    a2_neg = is_neg;
                    if (is_op) begin
                        pend_nxt = key_to_op(key_code);
                    end
                    if (is_bsp) begin
                        if (!op2_empty) begin
                            a2_bsp = 1'b1;
                        end else begin
                            pend_nxt  = OP_NULL;
                            nxt_state = S_OP1;
                        end
                    end
                    if (is_eq) begin
                        oper_nxt  = pend_op;
                        sel_nxt   = 1'b1;
                        nxt_state = S_DONE;
                    end
                end
                S_DONE: begin
                    if (is_digit) begin
                        a1_load   = 1'b1;
                        a2_clr    = 1'b1;
                        oper_nxt  = OP_NULL;
                        sel_nxt   = 1'b0;
                        nxt_state = S_OP1;
                    end
                    if (is_op) begin
                        a2_clr    = 1'b1;
                        pend_nxt  = key_to_op(key_code);
                        oper_nxt  = OP_NULL;
                        sel_nxt   = 1'b0;
                        nxt_state = S_OP2;
                    end
                end
                default: nxt_state = S_OP1;
            endcase
        end
    end

    // Edited operand for the display; operand1 stays visible until operand2 has a digit
    always_comb begin
        disp_val = operand1;
        if (cur_state != S_OP1 && !op2_empty) begin
            disp_val = operand2;
        end
    end

endmodule

// File: tb/tb_calc_key_entry.sv
// tb/tb_calc_key_entry.sv - randomized model-checked bench for calc_key_entry
module tb_calc_key_entry;

    localparam int MAXD = 6;

    logic        sw_clk = 1'b0;
    logic        rst;
    logic        key_valid;
    logic [4:0]  key_code;
    logic [31:0] operand1, operand2, disp_val;
    logic [2:0]  operator;
    logic        disp_sel;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_bad = 0;

    int m_sign[2];
    int m_mag[2];
    int m_state, m_pend, m_oper, m_sel;

    calc_key_entry dut (
        .sw_clk    (sw_clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .operand1  (operand1),
        .operand2  (operand2),
        .operator  (operator),
        .disp_val  (disp_val),
        .disp_sel  (disp_sel),
        .state     (state)
    );

    always #5 sw_clk = ~sw_clk;

    function automatic int ndig(input int m);
        int n = 0;
        while (m > 0) begin
            m = m / 10;
            n++;
        end
        return n;
    endfunction

    function automatic int mval(input int i);
        return m_sign[i] != 0 ? -m_mag[i] : m_mag[i];
    endfunction

    function automatic int mdisp();
        if (m_state == 0) return mval(0);
        return (m_mag[1] != 0) ? mval(1) : mval(0);
    endfunction

    task automatic m_reset();
        m_sign[0] = 0; m_sign[1] = 0; m_mag[0] = 0; m_mag[1] = 0;
        m_state = 0; m_pend = 0; m_oper = 0; m_sel = 0;
    endtask

    task automatic m_app(input int i, input int d);
        if (m_mag[i] == 0 && d == 0) return;
        if (ndig(m_mag[i]) < (m_sign[i] != 0 ? MAXD - 1 : MAXD)) m_mag[i] = m_mag[i] * 10 + d;
    endtask

    task automatic m_bsp(input int i);
        m_mag[i] = m_mag[i] / 10;
        if (m_mag[i] == 0) m_sign[i] = 0;
    endtask

    task automatic m_neg(input int i);
        if (m_mag[i] == 0) return;
        if (m_sign[i] == 0 && ndig(m_mag[i]) == MAXD) return;
        m_sign[i] = 1 - m_sign[i];
    endtask

    task automatic m_step(input int code);
        bit dig, op;
        dig = (code <= 9);
        op  = (code >= 10 && code <= 14);
        if (code >= 19) return;
        if (code == 16) begin
            m_reset();
            return;
        end
        case (m_state)
            0: begin
                if (dig) m_app(0, code);
                else if (code == 17) m_bsp(0);
                else if (code == 18) m_neg(0);
                else if (op) begin
                    m_pend = code - 9; m_mag[1] = 0; m_sign[1] = 0; m_state = 1;
                end
            end
            1: begin
                if (dig) m_app(1, code);
                else if (code == 18) m_neg(1);
                else if (op) m_pend = code - 9;
                else if (code == 17) begin
                    if (m_mag[1] > 0) m_bsp(1);
                    else begin m_pend = 0; m_state = 0; end
                end else if (code == 15) begin
                    m_oper = m_pend; m_sel = 1; m_state = 2;
                end
            end
            default: begin
                if (dig) begin
                    m_sign[0] = 0; m_mag[0] = code; m_mag[1] = 0; m_sign[1] = 0;
                    m_oper = 0; m_sel = 0; m_state = 0;
                end else if (op) begin
                    m_mag[1] = 0; m_sign[1] = 0; m_pend = code - 9;
                    m_oper = 0; m_sel = 0; m_state = 1;
                end
            end
        endcase
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge sw_clk) begin
        chk("operand1", int'($signed(operand1)), mval(0));
        chk("operand2", int'($signed(operand2)), mval(1));
        chk("operator", int'(operator), m_oper);
        chk("disp_val", int'($signed(disp_val)), mdisp());
        chk("disp_sel", int'(disp_sel), m_sel);
        chk("state", int'(state), m_state);
    end

    task automatic press(input int code, input bit valid = 1'b1);
        key_valid = valid;
        key_code  = code[4:0];
        @(posedge sw_clk);
        if (valid && rst) m_step(code);
        @(negedge sw_clk);
        key_valid = 1'b0;
    endtask

    task automatic seq(input int codes[$]);
        foreach (codes[k]) press(codes[k]);
    endtask

    task automatic async_reset_then_key(input int code);
        #2 rst = 1'b0;
        m_reset();
        #1;
        chk("async_rst_op1", int'($signed(operand1)), 0);
        chk("async_rst_op2", int'($signed(operand2)), 0);
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_disp", int'($signed(disp_val)), 0);
        @(negedge sw_clk);
        press(code);
        chk("rst_key_ignored", int'($signed(operand1)), 0);
        rst = 1'b1;
    endtask

    initial begin
        int r, code;
        bit v;
        m_reset();
        rst = 1'b0;
        key_valid = 1'b0;
        key_code = 5'd0;
        repeat (2) @(negedge sw_clk);
        chk("reset_op1", int'($signed(operand1)), 0);
        chk("reset_oper", int'(operator), 0);
        chk("reset_state", int'(state), 0);
        chk("reset_sel", int'(disp_sel), 0);
        rst = 1'b1;
        @(negedge sw_clk);

        seq('{16, 1, 2, 10, 3, 4, 15});
        chk("s1_op1", int'($signed(operand1)), 12);
        chk("s1_op2", int'($signed(operand2)), 34);
        chk("s1_oper", int'(operator), 1);
        chk("s1_sel", int'(disp_sel), 1);
        chk("s1_state", int'(state), 2);
        press(15);
        chk("s1_eq_hold", int'(operator), 1);
        press(9);
        chk("s5_op1", int'($signed(operand1)), 9);
        chk("s5_op2", int'($signed(operand2)), 0);
        chk("s5_oper", int'(operator), 0);
        chk("s5_sel", int'(disp_sel), 0);
        seq('{13, 4, 15});
        chk("s5b_op1", int'($signed(operand1)), 9);
        chk("s5b_op2", int'($signed(operand2)), 4);
        chk("s5b_oper", int'(operator), 4);

        seq('{16, 1, 2, 3, 4, 5, 6, 7});
        chk("s2_limit", int'($signed(operand1)), 123456);
        press(18);
        chk("s2_neg_full", int'($signed(operand1)), 123456);
        seq('{17, 18});
        chk("s2_neg", int'($signed(operand1)), -12345);
        press(6);
        chk("s2_neg_limit", int'($signed(operand1)), -12345);

        seq('{16, 0, 0, 7, 18, 11, 0, 15});
        chk("s3_op1", int'($signed(operand1)), -7);
        chk("s3_op2", int'($signed(operand2)), 0);
        chk("s3_oper", int'(operator), 2);

        seq('{16, 5, 12, 17});
        chk("s4_state", int'(state), 0);
        chk("s4_op1", int'($signed(operand1)), 5);
        press(15);
        chk("s4_oper", int'(operator), 0);
        chk("s4_state2", int'(state), 0);

        seq('{16, 1, 12, 3});
        chk("s6_state", int'(state), 1);
        chk("s6_op2", int'($signed(operand2)), 3);
        async_reset_then_key(4);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            v = 1'b1;
            if (r < 50)      code = $urandom_range(0, 9);
            else if (r < 62) code = $urandom_range(10, 14);
            else if (r < 70) code = 15;
            else if (r < 72) code = 16;
            else if (r < 83) code = 17;
            else if (r < 91) code = 18;
            else if (r < 95) code = $urandom_range(19, 31);
            else begin
                code = $urandom_range(0, 31);
                v = 1'b0;
            end
            if ($urandom_range(0, 399) == 0) async_reset_then_key(code);
            else press(code, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
